fifo_word_serializer: RTL and testbench
=======================================

// Module: fifo_word_serializer
// PURPOSE
//  Parametrised word-to-byte FIFO for the UART transmit path. Buffers DEPTH words of NBYTES bytes
//  each and streams them out one byte per read. Byte order is selectable. Successive words are
//  delivered back-to-back with no bubble. Sits between the packet/word producer and the UART TX
//  byte engine.
// PARAMETERS
//  NBYTES     8  bytes per word; word width = 8*NBYTES; >= 2
//  DEPTH      4  word entries in storage; power of 2, >= 2
//  MSB_FIRST  0  0: byte[7:0] first; 1: top byte first
// PORTS
//  clk_fifo_i  in   1                   single clock, all state on rising edge
//  reset_n     in   1                   asynchronous, active-low reset
//  flush       in   1                   sync clear of storage, serializer and overflow
//  wr_en       in   1                   push wr_data when !full
//  wr_data     in   8*NBYTES            word to buffer
//  full        out  1                   level == DEPTH
//  rd_en       in   1                   consume data_out when data_valid
//  data_out    out  8                   current byte (registered)
//  data_valid  out  1                   data_out holds an unconsumed byte
//  word_done   out  1                   1-cycle pulse after last byte of a word is consumed
//  empty       out  1                   level == 0 && !data_valid
//  level       out  $clog2(DEPTH)+1     words in storage (excludes word in serializer)
//  overflow    out  1                   sticky: wr_en seen while full
// BEHAVIOUR
//  Reset (reset_n=0, any time, mid-word included):
//   - storage, pointers and byte index all cleared
//   - outputs: data_out=0, data_valid=0, word_done=0, full=0, empty=1, level=0, overflow=0
//  Storage: circular buffer, wr/rd pointers of $clog2(DEPTH) bits, wrap modulo DEPTH.
//   - level updates +1 on push, -1 on load, unchanged on both in the same cycle
//  Push: wr_en && !full writes at wr_ptr.
//   - wr_en && full: word dropped, overflow<=1, no state change
//   - full is from the registered level, so a load in the same cycle does not admit the write
//  Serializer FSM, two states:
//   - IDLE: no word held, data_valid=0. If level>0: load word into shift reg, byte_idx<=0,
//     data_valid<=1, go to SEND.
//   - SEND: data_out = byte_idx-th byte per MSB_FIRST. On rd_en:
//     - byte_idx < NBYTES-1: byte_idx+1, next byte on data_out the next cycle
//     - byte_idx == NBYTES-1: word_done<=1 for 1 cycle. If level>0, load the next word the same
//       edge and stay in SEND (no bubble); else data_valid<=0, go to IDLE.
//   - rd_en while !data_valid is ignored.
//  Latency: push into an empty block (IDLE) -> data_valid=1 two edges later; first byte is
//   byte 0 (MSB_FIRST=0) or byte NBYTES-1 (MSB_FIRST=1).
//  Simultaneous push and load: both take effect; level unchanged.
//  flush (sync, lower priority than reset_n):
//   - clears storage, pointers, level, data_valid, byte_idx and overflow; FSM -> IDLE
//   - word_done not pulsed; wr_en in the flush cycle is dropped
//  data_out holds its last value while data_valid=0; only data_valid qualifies it.
// STRUCTURE
//  Package fifo_ser_pkg:
//   - BYTE_W=8
//   - state enum {S_IDLE, S_SEND}
//   - function byte_sel(word, idx, msb_first)
//  Sub-module fifo_word_mem: DEPTH x 8*NBYTES storage, pointers, level, full. Top holds the FSM,
//   shift register and flag logic.
// TESTING
//  1 Reset: hold reset_n=0 -> all outputs at reset values. Assert reset_n=0 mid-word (byte 3) ->
//    data_valid drops asynchronously; after release empty=1, level=0.
//  2 Single word, NBYTES=8, MSB_FIRST=0: push 64'h8877_6655_4433_2211, rd_en held high ->
//    data_out 11,22,...,88 on consecutive cycles; word_done one cycle after the 88 read; then
//    empty=1.
//  3 MSB_FIRST=1, same word -> 88,77,...,11 order.
//  4 Back-to-back: push 3 words, rd_en held high -> 24 consecutive valid bytes with no gap;
//    word_done pulses 3 times, 8 cycles apart.
//  5 Full/overflow, DEPTH=4, rd_en=0:
//    - push 5 words -> first goes to serializer, level=4, full=1
//    - push 6th -> overflow=1, level stays 4
//    - one load with a simultaneous push -> write still dropped
//  6 Flush in SEND at byte 5 with level=2 -> next cycle data_valid=0, level=0, empty=1,
//    overflow=0, no word_done; a new push then restarts at byte 0.

Source files
------------

// File: rtl/fifo_ser_pkg.sv
// Shared types and helpers for the word-to-byte transmit FIFO.
// byte_sel works on a zero-extended word so one function serves every NBYTES up to MAX_NBYTES.
package fifo_ser_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_NBYTES = 32;
  localparam int MAX_WORD_W = BYTE_W * MAX_NBYTES;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // idx counts bytes in transmit order; msb_first maps it onto the word from the top end
  function automatic logic [BYTE_W-1:0] byte_sel(
    input logic [MAX_WORD_W-1:0] word,
    input int unsigned           idx,
    input int unsigned           nbytes,
    input bit                    msb_first
  );
    int unsigned pos;
    pos = msb_first ? (nbytes - 1 - idx) : idx;
    return word[pos*BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/fifo_word_mem.sv
// Circular word store for the serializer: storage array, wrapping pointers, level and full.
// Push is refused when full and pop when empty, so callers may present raw requests.
module fifo_word_mem #(
  parameter int WORD_W = 64,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WORD_W-1:0] i_wr_data,
  output logic [WORD_W-1:0] o_rd_data,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_full
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && (r_level != '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fifo_word_serializer.sv
// Word-to-byte FIFO for the UART TX path: buffers words and streams them out one byte per read.
// The next word is loaded on the same edge the last byte is consumed, so words run back-to-back.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int NBYTES    = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk_fifo_i,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [BYTE_W*NBYTES-1:0]   wr_data,
  output logic                       full,
  input  logic                       rd_en,
  output logic [BYTE_W-1:0]          data_out,
  output logic                       data_valid,
  output logic                       word_done,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int WORD_W = BYTE_W * NBYTES;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [BYTE_W-1:0] r_data_out;
  logic              r_word_done;
  logic              r_overflow;

  logic [WORD_W-1:0] w_rd_data;
  logic [LVL_W-1:0]  w_level;
  logic              w_full;
  logic              w_push;
  logic              w_last;
  logic              w_advance;
  logic              w_load;
  logic [IDX_W-1:0]  w_next_idx;

  fifo_word_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk     (clk_fifo_i),
    .i_reset_n (reset_n),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_pop     (w_load),
    .i_wr_data (wr_data),
    .o_rd_data (w_rd_data),
    .o_level   (w_level),
    .o_full    (w_full)
  );

  assign w_push     = wr_en && !w_full && !flush;
  assign w_last     = (r_state == S_SEND) && rd_en && (r_byte_idx == LAST_IDX);
  assign w_advance  = (r_state == S_SEND) && rd_en && (r_byte_idx != LAST_IDX);
  assign w_load     = !flush && (w_level != '0) && ((r_state == S_IDLE) || w_last);
  assign w_next_idx = r_byte_idx + IDX_W'(1);

  // data_out is kept across flush and idle; data_valid alone qualifies it
  always_ff @(posedge clk_fifo_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_data_out  <= '0;
      r_word_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_word_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_word_done <= w_last;
      if (wr_en && w_full) r_overflow <= 1'b1;
      if (w_load) begin
        r_state    <= S_SEND;
        r_word     <= w_rd_data;
        r_byte_idx <= '0;
        r_data_out <= byte_sel(MAX_WORD_W'(w_rd_data), 0, NBYTES, MSB_FIRST);
      end else if (w_last) begin
        r_state    <= S_IDLE;
        r_byte_idx <= '0;
      end else if (w_advance) begin
        r_byte_idx <= w_next_idx;
        r_data_out <= byte_sel(MAX_WORD_W'(r_word), 32'(w_next_idx), NBYTES, MSB_FIRST);
      end
    end
  end

  assign full       = w_full;
  assign level      = w_level;
  assign data_out   = r_data_out;
  assign data_valid = (r_state == S_SEND);
  assign word_done  = r_word_done;
  assign overflow   = r_overflow;
  assign empty      = (w_level == '0) && (r_state == S_IDLE);

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer: two instances (LSB-first and MSB-first) share stimulus.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
module tb_fifo_word_serializer;

  localparam int NB = 8;
  localparam int DP = 4;
  localparam logic [63:0] W_T2 = 64'h8877_6655_4433_2211;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush   = 1'b0;
  logic        wr_en   = 1'b0;
  logic        rd_en   = 1'b0;
  logic [63:0] wr_data = '0;

  logic       full0, dv0, wd0, empty0, ovf0;
  logic [7:0] do0;
  logic [2:0] lvl0;
  logic       full1, dv1, wd1, empty1, ovf1;
  logic [7:0] do1;
  logic [2:0] lvl1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_word_serializer #(.NBYTES(NB), .DEPTH(DP), .MSB_FIRST(1'b0)) dut0 (
    .clk_fifo_i (clk),   .reset_n (reset_n), .flush (flush),
    .wr_en      (wr_en), .wr_data (wr_data), .full  (full0),
    .rd_en      (rd_en), .data_out(do0),     .data_valid (dv0),
    .word_done  (wd0),   .empty   (empty0),  .level (lvl0),
    .overflow   (ovf0)
  );

  fifo_word_serializer #(.NBYTES(NB), .DEPTH(DP), .MSB_FIRST(1'b1)) dut1 (
    .clk_fifo_i (clk),   .reset_n (reset_n), .flush (flush),
    .wr_en      (wr_en), .wr_data (wr_data), .full  (full1),
    .rd_en      (rd_en), .data_out(do1),     .data_valid (dv1),
    .word_done  (wd1),   .empty   (empty1),  .level (lvl1),
    .overflow   (ovf1)
  );

  typedef struct {
    logic       we;
    logic       re;
    logic       expValid;
    int         expIdx;
    logic       expWordDone;
    logic [2:0] expLevel;
    logic       expEmpty;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [7:0] byteOf(input logic [63:0] w, input int idx);
    return w[idx*8 +: 8];
  endfunction

  // word k carries bytes {k, j} in byte lane j, e.g. word 1 = 64'h1716151413121110
  function automatic logic [63:0] mkWord(input int k);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = {4'(k), 4'(j)};
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [63:0] wd, input logic re, input logic fl);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    flush   = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyReset();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] words[3];
    int          nBytes;
    int          gaps;
    int          nDone;
    int          doneCycle[4];
    bit          started;

    // single-word sequence, rd_en held high from the push onward
    vecs[0] = '{1'b1, 1'b1, 1'b0, 0, 1'b0, 3'd1, 1'b0};
    for (int k = 1; k <= 8; k++) vecs[k] = '{1'b0, 1'b1, 1'b1, k - 1, 1'b0, 3'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 3'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 3'd0, 1'b1};

    $display("[TB] reset values");
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst data_out",   do0,    8'h00);
    checkOutput("rst data_valid", dv0,    1'b0);
    checkOutput("rst word_done",  wd0,    1'b0);
    checkOutput("rst full",       full0,  1'b0);
    checkOutput("rst empty",      empty0, 1'b1);
    checkOutput("rst level",      lvl0,   3'd0);
    checkOutput("rst overflow",   ovf0,   1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] single word, both byte orders");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].we, W_T2, vecs[i].re, 1'b0);
      checkOutput($sformatf("t2[%0d] valid0", i), dv0, vecs[i].expValid);
      checkOutput($sformatf("t2[%0d] valid1", i), dv1, vecs[i].expValid);
      if (vecs[i].expValid) begin
        checkOutput($sformatf("t2[%0d] lsb data", i), do0, byteOf(W_T2, vecs[i].expIdx));
        checkOutput($sformatf("t3[%0d] msb data", i), do1, byteOf(W_T2, 7 - vecs[i].expIdx));
      end
      checkOutput($sformatf("t2[%0d] word_done", i), wd0, vecs[i].expWordDone);
      checkOutput($sformatf("t2[%0d] level", i), lvl0, vecs[i].expLevel);
      checkOutput($sformatf("t2[%0d] empty", i), empty0, vecs[i].expEmpty);
    end

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, W_T2, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("mid byte3 data", do0, 8'h44);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid async valid", dv0,    1'b0);
    checkOutput("mid async data",  do0,    8'h00);
    checkOutput("mid async empty", empty0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("mid post empty", empty0, 1'b1);
    checkOutput("mid post level", lvl0,   3'd0);
    checkOutput("mid post valid", dv0,    1'b0);

    $display("[TB] back-to-back words");
    for (int k = 0; k < 3; k++) words[k] = mkWord(k + 1);
    nBytes  = 0;
    gaps    = 0;
    nDone   = 0;
    started = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) applyStimulus(1'b1, words[c], 1'b1, 1'b0);
      else       applyStimulus(1'b0, '0, 1'b1, 1'b0);
      if (dv0) begin
        started = 1'b1;
        if (nBytes < 24)
          checkOutput($sformatf("b2b byte %0d", nBytes), do0, byteOf(words[nBytes/8], nBytes % 8));
        nBytes++;
      end else if (started && nBytes < 24) begin
        gaps++;
      end
      if (wd0) begin
        if (nDone < 4) doneCycle[nDone] = c;
        nDone++;
      end
    end
    checkOutput("b2b byte count", 64'(nBytes), 64'd24);
    checkOutput("b2b gaps",       64'(gaps),   64'd0);
    checkOutput("b2b done count", 64'(nDone),  64'd3);
    if (nDone >= 3) begin
      checkOutput("b2b done spacing 1", 64'(doneCycle[1] - doneCycle[0]), 64'd8);
      checkOutput("b2b done spacing 2", 64'(doneCycle[2] - doneCycle[1]), 64'd8);
    end

    $display("[TB] full and overflow");
    applyReset();
    for (int k = 1; k <= 5; k++) applyStimulus(1'b1, mkWord(k), 1'b0, 1'b0);
    checkOutput("full level",    lvl0,  3'd4);
    checkOutput("full flag",     full0, 1'b1);
    checkOutput("full valid",    dv0,   1'b1);
    checkOutput("full data",     do0,   8'h10);
    checkOutput("full no ovf",   ovf0,  1'b0);
    applyStimulus(1'b1, mkWord(6), 1'b0, 1'b0);
    checkOutput("ovf set",       ovf0,  1'b1);
    checkOutput("ovf level",     lvl0,  3'd4);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("ovf last byte", do0,   8'h17);
    applyStimulus(1'b1, mkWord(7), 1'b1, 1'b0);
    checkOutput("load+push word_done", wd0,   1'b1);
    checkOutput("load+push level",     lvl0,  3'd3);
    checkOutput("load+push full",      full0, 1'b0);
    checkOutput("load+push valid",     dv0,   1'b1);
    checkOutput("load+push data",      do0,   8'h20);
    checkOutput("load+push ovf",       ovf0,  1'b1);

    $display("[TB] flush mid-word");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("pre-flush level", lvl0, 3'd2);
    checkOutput("pre-flush data0", do0,  8'h30);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("pre-flush byte5", do0,  8'h35);
    applyStimulus(1'b1, mkWord(8), 1'b1, 1'b1);
    checkOutput("flush valid",     dv0,    1'b0);
    checkOutput("flush level",     lvl0,   3'd0);
    checkOutput("flush empty",     empty0, 1'b1);
    checkOutput("flush ovf",       ovf0,   1'b0);
    checkOutput("flush word_done", wd0,    1'b0);
    checkOutput("flush full",      full0,  1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("post-flush word_done", wd0,    1'b0);
    checkOutput("post-flush empty",     empty0, 1'b1);
    checkOutput("post-flush level",     lvl0,   3'd0);
    applyStimulus(1'b1, mkWord(9), 1'b0, 1'b0);
    checkOutput("restart level", lvl0, 3'd1);
    checkOutput("restart valid early", dv0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("restart valid", dv0,  1'b1);
    checkOutput("restart lsb",   do0,  8'h90);
    checkOutput("restart msb",   do1,  8'h97);
    checkOutput("restart lvl",   lvl0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
